// File: rtl/dc_pwm_capture.sv
// dc_pwm_capture: receive-side monitor for the DC motor H-bridge PWM drive pair.
// Measures each PWM period (active rising edge to active rising edge) and reports
// the drive direction, the duty in integer percent and the period length in clocks.
// A no-edge timeout reports 0 % or 100 % so a stuck output is still visible.
// Optional feature macro: DC_CAP_GLITCH_FILTER_EN enables a FILTER_LEN-deep
// stability filter on the active level. The default build uses the raw
// synchronized level.
module dc_pwm_capture #(
    parameter int CLK_FRE    = 50,
    parameter int TIMEOUT_MS = 40,
    parameter int FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dc_io,
    output logic        dc_dir,
    output logic [7:0]  dc_duty,
    output logic [23:0] period_cnt,
    output logic        duty_valid,
    output logic        fault
);

    localparam int          TO_CYC    = TIMEOUT_MS * 1000 * CLK_FRE;
    localparam logic [23:0] TO_LAST   = 24'(TO_CYC - 1);
    localparam logic [23:0] CNT_MAX   = 24'hFF_FFFF;
    localparam logic [2:0]  DIV_FIRST = 3'd6;

    // Elaboration-time parameter sanity checks
    if (TO_CYC < 1 || TO_CYC >= 16777216) begin : g_to_range
        $error("dc_pwm_capture: timeout window does not fit the 24-bit counter");
    end
    if (FILTER_LEN < 1) begin : g_flt_range
        $error("dc_pwm_capture: FILTER_LEN must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_DIV  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Saturating 24-bit increment shared by all counters
    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        logic [23:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + 24'd1;
        end
        return r;
    endfunction

    // high * 100 built from shifts: 100 = 64 + 32 + 4
    function automatic logic [30:0] times100(input logic [23:0] v);
        logic [30:0] w;
        w = {7'd0, v};
        return (w << 6) + (w << 5) + (w << 2);
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] sync1_q;
    logic [1:0] sync_q;
    logic       fault_q;
    logic       act_raw_s;
    logic       act_s;
    logic       dir_s;
    logic       act_prev_q;
    logic       rise_s;

    // Two-flop synchronizer; fault is taken from the first stage so it lines up with sync_q
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync_q  <= 2'b00;
            fault_q <= 1'b0;
        end else begin
            sync1_q <= dc_io;
            sync_q  <= sync1_q;
            fault_q <= sync1_q[1] & sync1_q[0];
        end
    end

    // Exactly one leg driven means the bridge is actively driving; 2'b11 counts as inactive
    assign act_raw_s = sync_q[1] ^ sync_q[0];
    assign dir_s     = sync_q[1];

`ifdef DC_CAP_GLITCH_FILTER_EN
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FLT_W-1:0] flt_cnt_q;
    logic [FLT_W-1:0] flt_cnt_d;
    logic             act_flt_q;
    logic             act_flt_d;

    // Accept a new active level only after it has held for FILTER_LEN samples
    always_comb begin
        flt_cnt_d = flt_cnt_q;
        act_flt_d = act_flt_q;
        if (act_raw_s == act_flt_q) begin
            flt_cnt_d = {FLT_W{1'b0}};
        end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            act_flt_d = act_raw_s;
            flt_cnt_d = {FLT_W{1'b0}};
        end else begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
        end
    end

    // Filter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt_q <= {FLT_W{1'b0}};
            act_flt_q <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            act_flt_q <= act_flt_d;
        end
    end

    assign act_s = act_flt_q;
`else
    assign act_s = act_raw_s;
`endif

    // Previous active level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            act_prev_q <= 1'b0;
        end else begin
            act_prev_q <= act_s;
        end
    end

    assign rise_s = act_s & ~act_prev_q;

    // ------------------------------------------------------------------
    // Measurement, division and reporting
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [23:0] period_q,    period_d;
    logic [23:0] high_q,      high_d;
    logic [23:0] to_cnt_q,    to_cnt_d;
    logic        dir_cur_q,   dir_cur_d;
    logic        dir_snap_q,  dir_snap_d;
    logic [30:0] rem_q,       rem_d;
    logic [23:0] den_q,       den_d;
    logic [5:0]  quot_q,      quot_d;
    logic [2:0]  step_q,      step_d;
    logic        dc_dir_q,    dc_dir_d;
    logic [7:0]  dc_duty_q,   dc_duty_d;
    logic [23:0] period_o_q,  period_o_d;
    logic        valid_q,     valid_d;

    logic        to_fire_s;
    logic [30:0] den_sh_s;
    logic        div_ge_s;
    logic        div_bit_s;

    // Timeout only applies while waiting for or measuring a period; an edge always wins
    assign to_fire_s = ((state_q == ST_IDLE) || (state_q == ST_MEAS)) && !rise_s
                       && (to_cnt_q >= TO_LAST);

    // Restoring division trial: divisor aligned to the current quotient bit
    assign den_sh_s = {7'd0, den_q} << step_q;
    assign div_ge_s = (rem_q >= den_sh_s);

    // Next-state logic: counters, FSM transitions, divider step and output staging
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        high_d     = high_q;
        to_cnt_d   = to_cnt_q;
        dir_cur_d  = dir_cur_q;
        dir_snap_d = dir_snap_q;
        rem_d      = rem_q;
        den_d      = den_q;
        quot_d     = quot_q;
        step_d     = step_q;
        dc_dir_d   = dc_dir_q;
        dc_duty_d  = dc_duty_q;
        period_o_d = period_o_q;
        valid_d    = 1'b0;
        div_bit_s  = 1'b0;

        // No-edge window restarts on every edge and on every timeout report
        if (rise_s || to_fire_s) begin
            to_cnt_d = 24'd0;
        end else begin
            to_cnt_d = sat_inc(to_cnt_q);
        end

        // Period and high-time counting runs in the background outside IDLE
        if (state_q != ST_IDLE) begin
            period_d = sat_inc(period_q);
            high_d   = act_s ? sat_inc(high_q) : high_q;
        end else begin
            period_d = period_q;
            high_d   = high_q;
        end

        // Every edge starts a new period, even when its snapshot is discarded
        if (rise_s) begin
            period_d  = 24'd1;
            high_d    = 24'd1;
            dir_cur_d = dir_s;
        end else begin
            dir_cur_d = dir_cur_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_MEAS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEAS: begin
                if (rise_s) begin
                    rem_d      = times100(high_q);
                    den_d      = period_q;
                    dir_snap_d = dir_cur_q;
                    quot_d     = 6'd0;
                    step_d     = DIV_FIRST;
                    state_d    = ST_DIV;
                end else if (to_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MEAS;
                end
            end
            ST_DIV: begin
                if (div_ge_s) begin
                    rem_d     = rem_q - den_sh_s;
                    div_bit_s = 1'b1;
                end else begin
                    rem_d     = rem_q;
                    div_bit_s = 1'b0;
                end
                quot_d = {quot_q[4:0], div_bit_s};
                step_d = step_q - 3'd1;
                if (step_q == 3'd0) begin
                    // Last quotient bit goes straight into the output register
                    dc_duty_d  = {1'b0, quot_q, div_bit_s};
                    dc_dir_d   = dir_snap_q;
                    period_o_d = den_q;
                    valid_d    = 1'b1;
                    state_d    = ST_OUT;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_OUT: begin
                state_d = ST_MEAS;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout report: a held active level reads as 100 %, anything else as 0 %
        if (to_fire_s) begin
            if (act_s) begin
                dc_duty_d = 8'd100;
                dc_dir_d  = dir_s;
            end else begin
                dc_duty_d = 8'd0;
                dc_dir_d  = dc_dir_q;
            end
            period_o_d = 24'd0;
            valid_d    = 1'b1;
        end else begin
            valid_d = valid_d;
        end
    end

    // State, counter, divider and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            period_q   <= 24'd0;
            high_q     <= 24'd0;
            to_cnt_q   <= 24'd0;
            dir_cur_q  <= 1'b0;
            dir_snap_q <= 1'b0;
            rem_q      <= 31'd0;
            den_q      <= 24'd0;
            quot_q     <= 6'd0;
            step_q     <= 3'd0;
            dc_dir_q   <= 1'b0;
            dc_duty_q  <= 8'd0;
            period_o_q <= 24'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            high_q     <= high_d;
            to_cnt_q   <= to_cnt_d;
            dir_cur_q  <= dir_cur_d;
            dir_snap_q <= dir_snap_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            quot_q     <= quot_d;
            step_q     <= step_d;
            dc_dir_q   <= dc_dir_d;
            dc_duty_q  <= dc_duty_d;
            period_o_q <= period_o_d;
            valid_q    <= valid_d;
        end
    end

    assign dc_dir     = dc_dir_q;
    assign dc_duty    = dc_duty_q;
    assign period_cnt = period_o_q;
    assign duty_valid = valid_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_dc_pwm_capture.sv
// Testbench for dc_pwm_capture (CLK_FRE=1, TIMEOUT_MS=5 -> 5000-clock timeout).
// An event-level reference model predicts every strobe from the list of rising
// edges of the synchronized active level; outputs are compared every cycle.
module tb_dc_pwm_capture;

    localparam int TO_CYC = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dc_io;
    logic        dc_dir;
    logic [7:0]  dc_duty;
    logic [23:0] period_cnt;
    logic        duty_valid;
    logic        fault;

    dc_pwm_capture #(
        .CLK_FRE    (1),
        .TIMEOUT_MS (5),
        .FILTER_LEN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dc_io      (dc_io),
        .dc_dir     (dc_dir),
        .dc_duty    (dc_duty),
        .period_cnt (period_cnt),
        .duty_valid (duty_valid),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at cycle", tag, obs, exp);
        end
    endtask

    // Reference model state
    int         cyc = 0;
    logic [1:0] m_s1;
    logic       m_act_prev;
    bit         m_meas;
    int         m_start, m_high, m_last_acc, m_last_evt;
    logic       m_dir_start;
    bit         pr_v, pt_v, pt_upd;
    int         pr_t, pr_per, pr_duty, pt_t, pt_duty;
    logic       pr_dir, pt_dir;
    logic       e_dir, e_valid, e_fault;
    int         e_duty, e_per;

    // One clock: advance the model by one cycle, then compare every output
    task automatic tick();
        logic [1:0] s_n;
        logic       a;
        logic       rise;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_s1 = 2'b00; m_act_prev = 1'b0; m_meas = 0;
            m_last_acc = -1000; m_last_evt = cyc - 1;
            pr_v = 0; pt_v = 0;
            e_dir = 1'b0; e_duty = 0; e_per = 0; e_valid = 1'b0; e_fault = 1'b0;
        end else begin
            s_n  = m_s1;
            m_s1 = dc_io;
            a    = s_n[1] ^ s_n[0];
            rise = a & ~m_act_prev;
            m_act_prev = a;
            e_fault = (s_n == 2'b11);
            if (rise) begin
                if (m_meas && (cyc - m_last_acc >= 9)) begin
                    pr_v = 1; pr_t = cyc + 8; pr_per = cyc - m_start;
                    pr_duty = (m_high * 100) / pr_per; pr_dir = m_dir_start;
                    m_last_acc = cyc;
                end
                m_meas = 1; m_start = cyc; m_high = 0; m_dir_start = s_n[1];
                m_last_evt = cyc;
            end else if (cyc - m_last_evt >= TO_CYC) begin
                pt_v = 1; pt_t = cyc + 1; pt_duty = a ? 100 : 0;
                pt_upd = a; pt_dir = s_n[1];
                m_meas = 0; m_last_evt = cyc;
            end
            if (m_meas && a) m_high++;
            e_valid = 1'b0;
            if (pr_v && pr_t == cyc) begin
                pr_v = 0; e_valid = 1'b1;
                e_duty = pr_duty; e_dir = pr_dir; e_per = pr_per;
            end
            if (pt_v && pt_t == cyc) begin
                pt_v = 0; e_valid = 1'b1;
                e_duty = pt_duty; e_per = 0;
                if (pt_upd) e_dir = pt_dir;
            end
        end
        check("duty_valid", duty_valid, e_valid);
        check("fault", fault, e_fault);
        check("dc_duty", dc_duty, e_duty);
        check("dc_dir", dc_dir, e_dir);
        check("period_cnt", period_cnt, e_per);
    endtask

    task automatic drive(input logic [1:0] v, input int n);
        dc_io = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int nv;
        rst   = 1'b1;
        dc_io = 2'b00;
        do_reset();
        check("rst_duty", dc_duty, 8'd0);
        check("rst_valid", duty_valid, 1'b0);
        check("rst_period", period_cnt, 24'd0);

        // Direction 1, 25 % duty, period 1000
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 250);
            drive(2'b00, 750);
        end
        check("t1_duty", dc_duty, 8'd25);
        check("t1_dir", dc_dir, 1'b1);
        check("t1_period", period_cnt, 24'd1000);

        // Direction 0, 33.3 % truncates to 33
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 333);
            drive(2'b00, 667);
        end
        check("t2_duty", dc_duty, 8'd33);
        check("t2_dir", dc_dir, 1'b0);

        // Idle line: timeout strobes every 5000 clocks with 0 %
        do_reset();
        dc_io = 2'b00;
        nv = 0;
        repeat (10001) begin
            tick();
            if (duty_valid) nv++;
        end
        check("t3_strobes", nv, 32'd2);
        check("t3_duty", dc_duty, 8'd0);
        check("t3_period", period_cnt, 24'd0);

        // Held drive reads 100 %; shoot-through reads 0 % with fault
        do_reset();
        drive(2'b10, 5100);
        check("t4_duty_hi", dc_duty, 8'd100);
        check("t4_dir_hi", dc_dir, 1'b1);
        drive(2'b11, 5100);
        check("t4_duty_st", dc_duty, 8'd0);
        check("t4_fault", fault, 1'b1);
        check("t4_dir_kept", dc_dir, 1'b1);

        // Reset in the middle of a high phase
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(2'b10, 250);
            drive(2'b00, 750);
        end
        drive(2'b10, 100);
        rst = 1'b1;
        tick();
        check("t5_duty", dc_duty, 8'd0);
        check("t5_period", period_cnt, 24'd0);
        rst = 1'b0;
        drive(2'b10, 150);
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 750);
            drive(2'b10, 250);
        end

        // Short periods are partly dropped, then a 20-clock period reports
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(2'b10, 3);
            drive(2'b00, 3);
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 5);
            drive(2'b00, 15);
        end
        check("t6_duty", dc_duty, 8'd25);
        check("t6_period", period_cnt, 24'd20);

        // Randomized periods, duties, directions and off levels
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int per, hi;
            logic [1:0] hv, lv;
            per = int'($urandom_range(300, 4));
            hi  = int'($urandom_range(per - 1, 1));
            hv  = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
            lv  = ($urandom_range(3, 0) == 0) ? 2'b11 : 2'b00;
            drive(hv, hi);
            drive(lv, per - hi);
        end
        drive(2'b00, 5200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
